instr_fetch_responder: RTL and testbench



---
 rtl/instr_fetch_responder_if.sv | 21 ++
 rtl/instr_fetch_responder.sv | 113 +++++++++++
 tb/tb_instr_fetch_responder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_responder_if.sv
// Instruction memory bus (waitrequest style) between the fetch responder and memory.
interface instr_fetch_responder_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    modport master (
        output mem_address,
        output mem_read,
        input  mem_waitrequest,
        input  mem_readdata
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        output mem_waitrequest,
        output mem_readdata
    );
endinterface

// File: rtl/instr_fetch_responder.sv
// Fetch responder: one bus read per PC value, instruction handed to decode.
// Optional last-fetch hit buffer enabled by defining FETCH_LAST_HIT_EN.
module instr_fetch_responder #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int unsigned MAX_WAIT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_addr,
    input  logic        pc_halt,
    input  logic        hold_in,
    output logic        fetch_stall,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        fetch_err,
    instr_fetch_responder_if.master mem
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DONE,
        HALTED,
        ERR
    } state_t;

    localparam logic [9:0] LAST_WAIT = 10'(MAX_WAIT - 1);

    state_t     state;
    logic [9:0] wait_cnt;

`ifdef FETCH_LAST_HIT_EN
    logic        hit_valid;
    logic [31:0] hit_tag;
    logic [31:0] hit_data;
    logic        hit;

    assign hit = hit_valid && (hit_tag == pc_addr);
`endif

    // PC enable must release in the very cycle decode accepts the word
    assign fetch_stall = reset || (state != DONE) || hold_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            mem.mem_read    <= 1'b0;
            mem.mem_address <= RESET_VECTOR;
            instr_out       <= 32'h0;
            instr_valid     <= 1'b0;
            fetch_err       <= 1'b0;
            wait_cnt        <= 10'd0;
`ifdef FETCH_LAST_HIT_EN
            hit_valid       <= 1'b0;
            hit_tag         <= 32'h0;
            hit_data        <= 32'h0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pc_halt) begin
                        state <= HALTED;
                    end else if (pc_addr[1:0] != 2'b00) begin
                        fetch_err <= 1'b1;
                        state     <= ERR;
`ifdef FETCH_LAST_HIT_EN
                    end else if (hit) begin
                        instr_out   <= hit_data;
                        instr_valid <= 1'b1;
                        state       <= DONE;
`endif
                    end else begin
                        mem.mem_address <= pc_addr;
                        mem.mem_read    <= 1'b1;
                        wait_cnt        <= 10'd0;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!mem.mem_waitrequest) begin
                        instr_out    <= mem.mem_readdata;
                        instr_valid  <= 1'b1;
                        mem.mem_read <= 1'b0;
                        state        <= DONE;
`ifdef FETCH_LAST_HIT_EN
                        hit_valid    <= 1'b1;
                        hit_tag      <= mem.mem_address;
                        hit_data     <= mem.mem_readdata;
`endif
                    end else if (wait_cnt == LAST_WAIT) begin
                        mem.mem_read <= 1'b0;
                        fetch_err    <= 1'b1;
                        state        <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                DONE: begin
                    if (!hold_in) begin
                        instr_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                HALTED, ERR: begin
                    mem.mem_read <= 1'b0;
                    instr_valid  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed plus randomized fetch sequences against a transaction-level model
// of latency, hit buffer, bus transaction count, halt and error behaviour.
module tb_instr_fetch_responder;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam int          MW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_addr = 32'h0;
    logic        pc_halt = 1'b0;
    logic        hold_in = 1'b0;
    logic        fetch_stall;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fetch_err;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int txn = 0;
    int exp_txn = 0;

    bit          m_valid = 1'b0;
    logic [31:0] m_tag = 32'h0;
    logic [31:0] m_data = 32'h0;

    instr_fetch_responder_if bus ();

    instr_fetch_responder #(
        .RESET_VECTOR(RV),
        .MAX_WAIT    (MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .pc_halt    (pc_halt),
        .hold_in    (hold_in),
        .fetch_stall(fetch_stall),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .fetch_err  (fetch_err),
        .mem        (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (bus.mem_read && !bus.mem_waitrequest) txn++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pc_halt = 1'b0;
        hold_in = 1'b0;
        #1;
        check1("rst_read", bus.mem_read, 1'b0);
        check32("rst_addr", bus.mem_address, RV);
        check1("rst_valid", instr_valid, 1'b0);
        check32("rst_instr", instr_out, 32'h0);
        check1("rst_err", fetch_err, 1'b0);
        check1("rst_stall", fetch_stall, 1'b1);
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata = 32'h0;
        tick();
        tick();
        check1("rst_stall_hold", fetch_stall, 1'b1);
        reset = 1'b0;
        m_valid = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; leaves it idle at a negedge.
    task automatic do_fetch(input logic [31:0] addr, input int nw,
                            input logic [31:0] data, input int hold,
                            input bit halt_mid);
        int t0;
        bit hit;
        logic [31:0] exp_data;
`ifdef FETCH_LAST_HIT_EN
        hit = m_valid && (m_tag == addr);
`else
        hit = 1'b0;
`endif
        exp_data = hit ? m_data : data;
        pc_addr = addr;
        hold_in = (hold > 0);
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata = $urandom;
        t0 = cyc;
        if (!hit) begin
            tick();
            check1("issue_read", bus.mem_read, 1'b1);
            check32("issue_addr", bus.mem_address, addr);
            check1("issue_valid", instr_valid, 1'b0);
            check1("issue_stall", fetch_stall, 1'b1);
            if (halt_mid) pc_halt = 1'b1;
            for (int i = 0; i < nw; i++) begin
                bus.mem_waitrequest = 1'b1;
                bus.mem_readdata = $urandom;
                tick();
                check1("wait_read", bus.mem_read, 1'b1);
                check32("wait_addr", bus.mem_address, addr);
                check1("wait_valid", instr_valid, 1'b0);
                check1("wait_stall", fetch_stall, 1'b1);
            end
            bus.mem_waitrequest = 1'b0;
            bus.mem_readdata = data;
            exp_txn++;
        end
        tick();
        check32("latency", 32'(cyc - t0), hit ? 32'd1 : 32'(2 + nw));
        check1("done_read", bus.mem_read, 1'b0);
        bus.mem_readdata = $urandom;
        for (int i = 0; i < hold; i++) begin
            check1("hold_valid", instr_valid, 1'b1);
            check32("hold_instr", instr_out, exp_data);
            check1("hold_stall", fetch_stall, 1'b1);
            tick();
        end
        hold_in = 1'b0;
        #1;
        check1("done_valid", instr_valid, 1'b1);
        check32("done_instr", instr_out, exp_data);
        check1("done_stall", fetch_stall, 1'b0);
        tick();
        check1("idle_valid", instr_valid, 1'b0);
        check1("idle_stall", fetch_stall, 1'b1);
        if (!hit) begin
            m_valid = 1'b1;
            m_tag = addr;
            m_data = data;
        end
    endtask

    task automatic expect_quiet(input string tag, input logic err, input int n);
        for (int i = 0; i < n; i++) begin
            pc_addr = RV + 32'(4 * $urandom_range(0, 7));
            tick();
            check1({tag, "_read"}, bus.mem_read, 1'b0);
            check1({tag, "_valid"}, instr_valid, 1'b0);
            check1({tag, "_stall"}, fetch_stall, 1'b1);
            check1({tag, "_err"}, fetch_err, err);
        end
    endtask

    initial begin
        logic [31:0] same;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata = 32'h0;
        #2;
        do_reset();
        pc_addr = RV;
        do_fetch(RV, 0, 32'h24020005, 0, 1'b0);
        do_fetch(RV + 32'd4, 3, 32'h8C430000, 4, 1'b0);

        same = $urandom;
        do_fetch(RV + 32'd8, 0, same, 0, 1'b0);
        do_fetch(RV + 32'd8, 2, same, 1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            do_fetch(RV + 32'(4 * $urandom_range(0, 3)),
                     $urandom_range(0, MW - 1), $urandom,
                     $urandom_range(0, 2), 1'b0);
        end

        do_fetch(RV + 32'h40, 1, 32'h00000013, 1, 1'b1);
        expect_quiet("halt_mid", 1'b0, 4);

        do_reset();
        pc_halt = 1'b1;
        expect_quiet("halt_idle", 1'b0, 4);

        do_reset();
        pc_addr = 32'hBFC00002;
        tick();
        check1("misalign_err", fetch_err, 1'b1);
        expect_quiet("misalign", 1'b1, 3);

        do_reset();
        pc_addr = RV + 32'd4;
        bus.mem_waitrequest = 1'b1;
        tick();
        check1("to_issue", bus.mem_read, 1'b1);
        for (int i = 1; i < MW; i++) begin
            tick();
            check1("to_wait_read", bus.mem_read, 1'b1);
            check1("to_wait_err", fetch_err, 1'b0);
        end
        tick();
        check1("to_read", bus.mem_read, 1'b0);
        check1("to_err", fetch_err, 1'b1);
        expect_quiet("timeout", 1'b1, 3);

        do_reset();
        pc_addr = RV + 32'h10;
        bus.mem_waitrequest = 1'b1;
        tick();
        check1("mid_issue", bus.mem_read, 1'b1);
        tick();
        do_reset();
        do_fetch(RV, 1, 32'h24020005, 0, 1'b0);

        check32("bus_txns", 32'(txn), 32'(exp_txn));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
